// File: rtl/midi_voice_allocator.sv
// Polyphonic MIDI Note On/Off decoder with oldest-voice stealing.
// Ports: clock/reset, inMidiByte+inMidiReady in; per-voice note/vel/gate/trigger + active count out.
module midi_voice_allocator #(
  parameter int NUM_VOICES = 4,
  parameter int CHANNEL    = 0,
  parameter int OMNI       = 0,
  parameter int AGE_W      = 8
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [7:0]              inMidiByte,
  input  logic                    inMidiReady,
  output logic [7*NUM_VOICES-1:0] outNote,
  output logic [7*NUM_VOICES-1:0] outVelocity,
  output logic [NUM_VOICES-1:0]   outGate,
  output logic [NUM_VOICES-1:0]   outTrigger,
  output logic [4:0]              outActiveCount
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_D1,
    WAIT_D2
  } state_t;

  localparam logic [3:0] CHAN = 4'(CHANNEL);

  state_t state;
  state_t stateNext;

  logic isRealTime;
  logic isSystem;
  logic isStatus;
  logic isNoteType;
  logic chanOk;
  logic acceptStatus;

  logic latchStatus;
  logic latchNote;
  logic issueEvent;

  logic       statusOn;
  logic [6:0] dataNote;

  logic       evValid;
  logic       evOn;
  logic [6:0] evNote;
  logic [6:0] evVel;

  logic [6:0]       noteR [NUM_VOICES];
  logic [6:0]       velR  [NUM_VOICES];
  logic [AGE_W-1:0] ageR  [NUM_VOICES];
  logic [NUM_VOICES-1:0] gateR;
  logic [NUM_VOICES-1:0] trigR;

  logic [NUM_VOICES-1:0] selMask;
  logic [NUM_VOICES-1:0] stealMask;
  logic [NUM_VOICES-1:0] offMask;
  logic [NUM_VOICES-1:0] gateNext;
  logic [AGE_W-1:0]      bestAge;
  logic                  found;
  logic [4:0]            countNext;

  assign isRealTime   = inMidiByte[7:3] == 5'b11111;
  assign isSystem     = inMidiByte[7:4] == 4'hF;
  assign isStatus     = inMidiByte[7];
  assign isNoteType   = inMidiByte[7:5] == 3'b100;
  assign chanOk       = (OMNI != 0) || (inMidiByte[3:0] == CHAN);
  assign acceptStatus = isNoteType && chanOk;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Real-time bytes fall through untouched so they can sit mid-message.
  always_comb begin
    stateNext = state;
    if (inMidiReady && !isRealTime) begin
      if (isSystem) begin
        stateNext = IDLE;
      end else if (isStatus) begin
        stateNext = acceptStatus ? WAIT_D1 : IDLE;
      end else begin
        case (state)
          IDLE:    stateNext = IDLE;
          WAIT_D1: stateNext = WAIT_D2;
          WAIT_D2: stateNext = WAIT_D1;
          default: stateNext = IDLE;
        endcase
      end
    end
  end

  always_comb begin
    latchStatus = inMidiReady && acceptStatus;
    latchNote   = 1'b0;
    issueEvent  = 1'b0;
    if (inMidiReady && !isStatus) begin
      latchNote  = state == WAIT_D1;
      issueEvent = state == WAIT_D2;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      statusOn <= 1'b0;
      dataNote <= '0;
      evValid  <= 1'b0;
      evOn     <= 1'b0;
      evNote   <= '0;
      evVel    <= '0;
    end else begin
      if (latchStatus) statusOn <= inMidiByte[4];
      if (latchNote) dataNote <= inMidiByte[6:0];
      evValid <= issueEvent;
      if (issueEvent) begin
        // Note On with zero velocity is a Note Off.
        evOn   <= statusOn && (inMidiByte[6:0] != 7'd0);
        evNote <= dataNote;
        evVel  <= inMidiByte[6:0];
      end
    end
  end

  // Priority: retrigger same note, else lowest free, else oldest.
  always_comb begin
    found     = 1'b0;
    selMask   = '0;
    stealMask = '0;
    bestAge   = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (!found && gateR[v] && noteR[v] == evNote) begin
        selMask[v] = 1'b1;
        found      = 1'b1;
      end
    end
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (!found && !gateR[v]) begin
        selMask[v] = 1'b1;
        found      = 1'b1;
      end
    end
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (v == 0 || ageR[v] > bestAge) begin
        bestAge      = ageR[v];
        stealMask    = '0;
        stealMask[v] = 1'b1;
      end
    end
    if (!found) selMask = stealMask;
  end

  always_comb begin
    offMask = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      offMask[v] = gateR[v] && noteR[v] == evNote;
    end
  end

  always_comb begin
    gateNext = gateR;
    if (evValid) begin
      gateNext = evOn ? (gateR | selMask) : (gateR & ~offMask);
    end
    countNext = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      countNext = countNext + 5'(gateNext[v]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      gateR          <= '0;
      trigR          <= '0;
      outActiveCount <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        noteR[v] <= '0;
        velR[v]  <= '0;
        ageR[v]  <= '0;
      end
    end else begin
      gateR          <= gateNext;
      outActiveCount <= countNext;
      trigR          <= (evValid && evOn) ? selMask : '0;
      if (evValid && evOn) begin
        for (int v = 0; v < NUM_VOICES; v++) begin
          if (selMask[v]) begin
            noteR[v] <= evNote;
            velR[v]  <= evVel;
            ageR[v]  <= '0;
          end else if (gateR[v] && ageR[v] != '1) begin
            ageR[v] <= ageR[v] + AGE_W'(1);
          end
        end
      end
    end
  end

  always_comb begin
    outNote     = '0;
    outVelocity = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      outNote[7*v +: 7]     = noteR[v];
      outVelocity[7*v +: 7] = velR[v];
    end
  end

  assign outGate    = gateR;
  assign outTrigger = trigR;

endmodule

// File: tb/tb_midi_voice_allocator.sv
// Directed bench for midi_voice_allocator (4 voices, channel 0).
// Expected snapshots are queued when stimulus is driven, popped on check.
module tb_midi_voice_allocator;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  inMidiByte = '0;
  logic        inMidiReady = 1'b0;
  logic [27:0] outNote;
  logic [27:0] outVelocity;
  logic [3:0]  outGate;
  logic [3:0]  outTrigger;
  logic [4:0]  outActiveCount;

  int checks = 0;
  int failures = 0;

  typedef struct {
    string       tag;
    logic [27:0] note;
    logic [27:0] vel;
    logic [3:0]  gate;
    logic [3:0]  trig;
    logic [4:0]  cnt;
  } exp_t;

  exp_t sb[$];

  midi_voice_allocator #(
    .NUM_VOICES(4),
    .CHANNEL(0),
    .OMNI(0),
    .AGE_W(8)
  ) dut (
    .clock(clock),
    .reset(reset),
    .inMidiByte(inMidiByte),
    .inMidiReady(inMidiReady),
    .outNote(outNote),
    .outVelocity(outVelocity),
    .outGate(outGate),
    .outTrigger(outTrigger),
    .outActiveCount(outActiveCount)
  );

  always #10 clock = ~clock;

  function automatic logic [27:0] p4(input logic [6:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic sendByte(input logic [7:0] b);
    inMidiByte  = b;
    inMidiReady = 1'b1;
    @(posedge clock);
    #1;
    inMidiReady = 1'b0;
  endtask

  task automatic doReset();
    reset       = 1'b1;
    inMidiReady = 1'b0;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic push(input string tag, input logic [27:0] n, v,
                      input logic [3:0] g, t, input logic [4:0] c);
    exp_t e;
    e.tag  = tag;
    e.note = n;
    e.vel  = v;
    e.gate = g;
    e.trig = t;
    e.cnt  = c;
    sb.push_back(e);
  endtask

  task automatic checkNow();
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("FAIL scoreboard_empty observed=0 expected=nonzero");
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      assert (outNote === e.note) else begin
        failures++;
        $error("FAIL %s_note observed=%h expected=%h", e.tag, outNote, e.note);
      end
      checks++;
      assert (outVelocity === e.vel) else begin
        failures++;
        $error("FAIL %s_vel observed=%h expected=%h", e.tag, outVelocity, e.vel);
      end
      checks++;
      assert (outGate === e.gate) else begin
        failures++;
        $error("FAIL %s_gate observed=%b expected=%b", e.tag, outGate, e.gate);
      end
      checks++;
      assert (outTrigger === e.trig) else begin
        failures++;
        $error("FAIL %s_trig observed=%b expected=%b", e.tag, outTrigger, e.trig);
      end
      checks++;
      assert (outActiveCount === e.cnt) else begin
        failures++;
        $error("FAIL %s_count observed=%0d expected=%0d", e.tag, outActiveCount, e.cnt);
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    push("reset", '0, '0, 4'b0000, 4'b0000, 5'd0);
    checkNow();

    sendByte(8'h90); sendByte(8'h3C); sendByte(8'h64);
    push("on_latency", '0, '0, 4'b0000, 4'b0000, 5'd0);
    checkNow();
    step();
    push("on_first", p4(7'h3C, 0, 0, 0), p4(7'h64, 0, 0, 0),
         4'b0001, 4'b0001, 5'd1);
    checkNow();
    step();
    push("on_trig_end", p4(7'h3C, 0, 0, 0), p4(7'h64, 0, 0, 0),
         4'b0001, 4'b0000, 5'd1);
    checkNow();

    sendByte(8'h80); sendByte(8'h3C); sendByte(8'h00);
    step();
    push("off_first", p4(7'h3C, 0, 0, 0), p4(7'h64, 0, 0, 0),
         4'b0000, 4'b0000, 5'd0);
    checkNow();

    doReset();
    sendByte(8'h90); sendByte(8'h3C); sendByte(8'h40);
    sendByte(8'h3E); sendByte(8'h40);
    sendByte(8'h3C); sendByte(8'h00);
    step();
    push("running", p4(7'h3C, 7'h3E, 0, 0), p4(7'h40, 7'h40, 0, 0),
         4'b0010, 4'b0000, 5'd1);
    checkNow();

    doReset();
    sendByte(8'h90);
    sendByte(8'h3C); sendByte(8'h50);
    sendByte(8'h3E); sendByte(8'h50);
    sendByte(8'h40); sendByte(8'h50);
    sendByte(8'h41); sendByte(8'h50);
    step();
    push("fill4", p4(7'h3C, 7'h3E, 7'h40, 7'h41), {4{7'h50}},
         4'b1111, 4'b1000, 5'd4);
    checkNow();
    sendByte(8'h43); sendByte(8'h50);
    step();
    push("steal_v0", p4(7'h43, 7'h3E, 7'h40, 7'h41), {4{7'h50}},
         4'b1111, 4'b0001, 5'd4);
    checkNow();
    sendByte(8'h45); sendByte(8'h50);
    step();
    push("steal_v1", p4(7'h43, 7'h45, 7'h40, 7'h41), {4{7'h50}},
         4'b1111, 4'b0010, 5'd4);
    checkNow();

    doReset();
    sendByte(8'h90); sendByte(8'h3C); sendByte(8'h20);
    step();
    push("retrig_a", p4(7'h3C, 0, 0, 0), p4(7'h20, 0, 0, 0),
         4'b0001, 4'b0001, 5'd1);
    checkNow();
    sendByte(8'h3C); sendByte(8'h70);
    step();
    push("retrig_b", p4(7'h3C, 0, 0, 0), p4(7'h70, 0, 0, 0),
         4'b0001, 4'b0001, 5'd1);
    checkNow();

    doReset();
    sendByte(8'h91); sendByte(8'h3C); sendByte(8'h64);
    step();
    push("other_chan", '0, '0, 4'b0000, 4'b0000, 5'd0);
    checkNow();
    sendByte(8'h90); sendByte(8'h3C); sendByte(8'hF8); sendByte(8'h64);
    step();
    push("realtime", p4(7'h3C, 0, 0, 0), p4(7'h64, 0, 0, 0),
         4'b0001, 4'b0001, 5'd1);
    checkNow();
    sendByte(8'h90); sendByte(8'h3C); sendByte(8'hF0); sendByte(8'h64);
    step();
    push("sysex_abort", p4(7'h3C, 0, 0, 0), p4(7'h64, 0, 0, 0),
         4'b0001, 4'b0000, 5'd1);
    checkNow();
    sendByte(8'h90); sendByte(8'h3C); sendByte(8'h00);
    step();
    push("vel0_off", p4(7'h3C, 0, 0, 0), p4(7'h64, 0, 0, 0),
         4'b0000, 4'b0000, 5'd0);
    checkNow();

    sendByte(8'h90);
    doReset();
    push("mid_reset", '0, '0, 4'b0000, 4'b0000, 5'd0);
    checkNow();
    sendByte(8'h3C); sendByte(8'h64);
    step();
    push("post_reset", '0, '0, 4'b0000, 4'b0000, 5'd0);
    checkNow();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/midi_voice_allocator.md
Name: midi_voice_allocator

Overview:
Parametrised polyphonic successor to the single-voice MIDI parser stage. Consumes the byte stream from MIDIIn (byte + one-cycle ready strobe) and decodes Note On/Off with running status on one channel or in omni mode. Assigns notes to NUM_VOICES voice slots with oldest-voice stealing, and drives per-voice note, velocity, gate and trigger to a bank of sample generators and envelope followers.

Parameters:
NUM_VOICES, 4, number of voice slots (1..16)
CHANNEL, 0, MIDI channel accepted (0..15); ignored when OMNI=1
OMNI, 0, 1 = accept Note On/Off on all channels
AGE_W, 8, width of per-voice saturating age counter

Ports:
clock  in  1  system clock (50 MHz)
reset  in  1  synchronous, active-high reset
inMidiByte  in  8  received MIDI byte
inMidiReady  in  1  one-cycle strobe, inMidiByte valid; may assert on consecutive cycles
outNote  out  7*NUM_VOICES  note number per voice, voice v at [7v+6:7v]
outVelocity  out  7*NUM_VOICES  velocity per voice, same packing
outGate  out  NUM_VOICES  1 while voice is held
outTrigger  out  NUM_VOICES  one-cycle pulse when a voice is (re)started
outActiveCount  out  5  number of gated voices

Behaviour:
- Reset: all outputs 0; parser in IDLE; running status cleared; all ages 0. Reset mid-message discards the partial message.
- Only cycles with inMidiReady=1 are processed. One byte per cycle is sustained.
- Byte classes:
  - 0xF8-0xFF (real-time): ignored, with no state change.
  - 0xF0-0xF7: clear running status and go to IDLE.
  - 0x80-0xEF: if type is 0x8/0x9 and the channel matches (or OMNI=1), latch the status and go to WAIT_D1. Otherwise clear running status and go to IDLE.
  - 0x00-0x7F: handled according to parser state.
- Parser FSM:
  - IDLE: data bytes ignored.
  - WAIT_D1: data byte is latched as note; go to WAIT_D2.
  - WAIT_D2: data byte is latched as velocity; issue event; return to WAIT_D1 (running status).
- Event latency: the second data byte is sampled at edge k; the event is registered at edge k; outputs update at edge k+1. outTrigger is high for exactly the cycle after edge k+1.
- Note On with velocity 0 is treated as Note Off.
- Note On allocation, in priority order:
  1. A gated voice already holding the same note is retriggered: velocity updated, trigger pulsed, age reset.
  2. Otherwise the lowest-index non-gated voice is used.
  3. Otherwise the voice with maximum age is stolen (lowest index on tie). Its note and velocity are replaced, gate stays 1, and trigger is pulsed.
- Age update on Note On: the selected voice's age becomes 0. Every other gated voice increments its age, saturating at 2^AGE_W-1. Non-gated voices keep their age.
- Note Off: clear outGate for every gated voice holding that note. outNote and outVelocity are retained for the envelope release. A Note Off for an unheld note has no effect and no trigger.
- outActiveCount is the registered popcount of outGate, updated on the same edge as outGate.
- Events arriving on consecutive cycles (minimum 2-byte spacing under running status) are each fully processed; no event is dropped.
- Non-matching channel traffic never alters voice state.

Test Plan:
- Reset, then 0x90 0x3C 0x64 -> voice0 note 0x3C, vel 0x64, gate 1, trigger pulse 1 cycle at latency 2, outActiveCount=1; then 0x80 0x3C 0x00 -> voice0 gate 0, note/vel retained, count=0.
- Running status: 0x90 0x3C 0x40 0x3E 0x40 0x3C 0x00 -> voice0=0x3C, voice1=0x3E, then voice0 gate cleared; voice1 still gated.
- Stealing with NUM_VOICES=4: Note On 60,62,64,65, then 67 -> voice0 (oldest) becomes 67 with trigger pulse; gates remain 4'b1111; a further Note On 69 steals voice1.
- Retrigger: Note On 60 vel 0x20, then Note On 60 vel 0x70 -> same voice, vel 0x70, second trigger, no second voice allocated.
- Filtering (CHANNEL=0, OMNI=0): 0x91 0x3C 0x64 -> no change. Then 0x90 0x3C, 0xF8, 0x64 -> note allocated (real-time byte ignored). Then 0x90 0x3C, 0xF0, 0x64 -> no event.
- Reset asserted between 0x90 and 0x3C -> all outputs 0; subsequent 0x3C 0x64 is ignored (IDLE).
